otter_pipe_ctrl: RTL and testbench
==================================

# otter_pipe_ctrl

Pipeline sequencing controller for the 5-stage OTTER (IF, DE, EX, MEM, WB). It owns the per-stage valid bits and the fetch/stall/flush controls, and it inserts load-use bubbles and squashes wrong-path instructions on taken control transfers. It also runs the interrupt entry sequence (synchronize, drain, redirect to mtvec) and supplies the CSR block with the `mepc` value and an `intTaken` pulse.

## Interface
- SYNC_STAGES, 2: flip-flop depth of the INTR synchronizer (≥2).
- CLK  in  1  system clock; all state updates on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- PROG_RESET  in  1  synchronous reset from the serial programmer; same effect as RESET_N, applied on the clock edge.
- INTR  in  1  external interrupt, asynchronous level.
- MIE  in  1  interrupt enable from the CSR block.
- FETCH_PC  in  32  current PC register value.
- DE_PC  in  32  PC of the instruction in DE (IF_ID latch).
- DE_RS1_ADDR, DE_RS2_ADDR  in  5 each  source register addresses in DE.
- DE_RS1_USED, DE_RS2_USED  in  1 each  source-operand-used flags in DE.
- EX_PC  in  32  PC of the instruction in EX.
- EX_RD_ADDR  in  5  destination register in EX.
- EX_MEM_READ  in  1  the EX instruction is a load.
- EX_REDIRECT  in  1  the EX instruction is a taken branch, JAL, or JALR; the datapath selects the target.
- PC_WRITE  out  1  PC register load enable.
- IF_ID_WRITE  out  1  IF_ID latch enable (0 = hold).
- DE_EX_BUBBLE  out  1  force the DE_EX latch to a NOP/invalid.
- INT_TAKEN  out  1  one-cycle pulse; the datapath selects mtvec and the CSR block captures EPC.
- EPC  out  32  return address for `mepc`; valid while INT_TAKEN is high.
- V_DE, V_EX, V_MEM, V_WB  out  1 each  stage valid bits; the datapath ANDs them into regWrite, memWrite, memRead2, and csrWrite.

## Operation
- Valid bits:
  - V_WB <= V_MEM
  - V_MEM <= V_EX
  - V_EX <= V_DE & !DE_EX_BUBBLE
  - V_DE <= 0 when squash, or when state ≠ IDLE; holds when a stall is active; otherwise 1.
- Load-use stall:
  - Condition: `stall = V_EX & EX_MEM_READ & EX_RD_ADDR≠0 & V_DE & ((DE_RS1_USED & DE_RS1_ADDR==EX_RD_ADDR) | (DE_RS2_USED & DE_RS2_ADDR==EX_RD_ADDR))`.
  - Response: PC_WRITE=0, IF_ID_WRITE=0, DE_EX_BUBBLE=1.
- Redirect:
  - Condition: `redirect = V_EX & EX_REDIRECT`.
  - Response: PC_WRITE=1, squash (V_DE<=0), DE_EX_BUBBLE=1.
  - Redirect overrides stall; the stalled instruction is on the wrong path.
- Interrupt pending:
  - `pending <= (pending | (int_sync & MIE)) & !INT_TAKEN`. Clear wins over a same-cycle set.
  - An INTR pulse shorter than one cycle may be missed; this is acceptable.
- FSM IDLE/DRAIN/TAKE:
  - IDLE: normal flow. PC_WRITE = !stall | redirect. IF_ID_WRITE = !stall.
  - IDLE→DRAIN when pending & !stall & !redirect (acceptance cycle).
    - Latch EPC: DE_PC if V_DE, else FETCH_PC.
    - Outputs: PC_WRITE=0, DE_EX_BUBBLE=1, V_DE<=0.
    - The EX instruction continues to MEM.
  - DRAIN: PC_WRITE=0, DE_EX_BUBBLE=1. Exit to TAKE when V_MEM=0 and V_WB=0.
  - TAKE: one cycle. INT_TAKEN=1, PC_WRITE=1 (mtvec), V_DE<=0. Next state IDLE.
- MIE falling after acceptance does not abort the sequence.
- Redirect cannot occur in DRAIN or TAKE, since EX holds a bubble. Defensive rule: ignore EX_REDIRECT outside IDLE.

## Timing
- Reset values (RESET_N low, or PROG_RESET at the edge):
  - State IDLE, pending=0, synchronizer=0, EPC=0, all V_* = 0.
  - Outputs PC_WRITE=1, IF_ID_WRITE=1, DE_EX_BUBBLE=0, INT_TAKEN=0.
- V_DE first rises on the edge after reset release. The first fetch then enters DE.
- Stall/redirect outputs are combinational from the current-cycle inputs, with no added latency.
- A load-use stall lasts exactly 1 cycle, because the load advances to MEM.
- A redirect costs 2 bubbles (DE and EX squashed).
- Interrupt latency, INTR rise to INT_TAKEN: SYNC_STAGES + 1 (pending) + 1 (acceptance) + 2 (drain) + 1, which is 7 cycles at the default setting. This adds 1 cycle per blocked acceptance cycle.
- Once INT_TAKEN fires, the mtvec fetch is valid in DE 2 cycles later.

## Test plan
- Reset: hold RESET_N low mid-DRAIN, then release -> state IDLE, all V_*=0, INT_TAKEN never pulses; V_DE=1 one edge after release.
- Load-use: EX=lw x5 (V_EX=1), DE uses rs2=x5 -> exactly one cycle of PC_WRITE=0, IF_ID_WRITE=0, DE_EX_BUBBLE=1; the next cycle V_EX=0, V_MEM=1. With EX_RD_ADDR=0 -> no stall.
- Redirect while stalled: EX_REDIRECT=1 together with the stall condition -> PC_WRITE=1, DE_EX_BUBBLE=1, V_DE=0 next cycle; V_EX=0 for 2 consecutive cycles.
- Interrupt: MIE=1, INTR pulsed high for 3 cycles with DE_PC=0x100 valid -> INT_TAKEN 1-cycle pulse 7 cycles after INTR rise, EPC=0x100, V_MEM=V_WB=0 in the TAKE cycle; pending=0 afterwards.
- Blocked acceptance: pending with EX redirect to 0x200 -> acceptance deferred until the redirect completes; EPC=0x200 (FETCH_PC).
- PROG_RESET asserted for 1 cycle during DRAIN -> everything returns to IDLE on that edge with valids cleared; INTR with MIE=0 -> no INT_TAKEN.

Source files
------------

// File: rtl/otter_pipe_ctrl.sv
// OTTER 5-stage pipeline sequencing: stage valid bits, load-use / redirect
// hazard control, and the interrupt entry sequence (sync, drain, mtvec).
module otter_pipe_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        PROG_RESET,
  input  logic        INTR,
  input  logic        MIE,
  input  logic [31:0] FETCH_PC,
  input  logic [31:0] DE_PC,
  input  logic [4:0]  DE_RS1_ADDR,
  input  logic [4:0]  DE_RS2_ADDR,
  input  logic        DE_RS1_USED,
  input  logic        DE_RS2_USED,
  input  logic [31:0] EX_PC,
  input  logic [4:0]  EX_RD_ADDR,
  input  logic        EX_MEM_READ,
  input  logic        EX_REDIRECT,
  output logic        PC_WRITE,
  output logic        IF_ID_WRITE,
  output logic        DE_EX_BUBBLE,
  output logic        INT_TAKEN,
  output logic [31:0] EPC,
  output logic        V_DE,
  output logic        V_EX,
  output logic        V_MEM,
  output logic        V_WB
);
  localparam int STAGES = 3;

  typedef enum logic [1:0] {IDLE, DRAIN, TAKE} state_t;

  state_t                 state, state_nxt;
  logic [STAGES:0]        vld_pipe;  // [0]=DE, [1]=EX, [2]=MEM, [3]=WB
  logic [SYNC_STAGES-1:0] sync;
  logic [31:0]            epc_q;
  logic                   int_sync, pending, hazard, stall, redirect, accept, v_de_nxt;
  logic                   unused_ex_pc;

  // EX_PC is part of the datapath-facing interface but not needed for control.
  assign unused_ex_pc = ^EX_PC;

  assign int_sync = sync[SYNC_STAGES-1];
  assign {V_WB, V_MEM, V_EX, V_DE} = vld_pipe;
  assign EPC = epc_q;

  assign hazard   = (DE_RS1_USED && (DE_RS1_ADDR == EX_RD_ADDR)) ||
                    (DE_RS2_USED && (DE_RS2_ADDR == EX_RD_ADDR));
  assign stall    = V_EX && EX_MEM_READ && (EX_RD_ADDR != '0) && V_DE && hazard;
  // Outside IDLE EX only ever holds a bubble; redirect is masked defensively.
  assign redirect = (state == IDLE) && V_EX && EX_REDIRECT;
  assign accept   = (state == IDLE) && pending && !stall && !redirect;

  always_comb begin
    state_nxt    = state;
    PC_WRITE     = 1'b1;
    IF_ID_WRITE  = !stall;
    DE_EX_BUBBLE = 1'b0;
    INT_TAKEN    = 1'b0;
    v_de_nxt     = 1'b1;
    unique case (state)
      IDLE: begin
        PC_WRITE     = !stall || redirect;
        DE_EX_BUBBLE = stall || redirect;
        if (redirect) begin
          v_de_nxt = 1'b0;
        end else if (accept) begin
          state_nxt    = DRAIN;
          PC_WRITE     = 1'b0;
          DE_EX_BUBBLE = 1'b1;
          v_de_nxt     = 1'b0;
        end else if (stall) begin
          v_de_nxt = V_DE;
        end
      end
      DRAIN: begin
        PC_WRITE     = 1'b0;
        DE_EX_BUBBLE = 1'b1;
        v_de_nxt     = 1'b0;
        if (!V_MEM && !V_WB) state_nxt = TAKE;
      end
      TAKE: begin
        INT_TAKEN = 1'b1;
        v_de_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      sync     <= '0;
      pending  <= 1'b0;
      vld_pipe <= '0;
      epc_q    <= '0;
    end else if (PROG_RESET) begin
      state    <= IDLE;
      sync     <= '0;
      pending  <= 1'b0;
      vld_pipe <= '0;
      epc_q    <= '0;
    end else begin
      state    <= state_nxt;
      sync     <= {sync[SYNC_STAGES-2:0], INTR};
      // Clear by INT_TAKEN wins over a same-cycle set.
      pending  <= (pending || (int_sync && MIE)) && !INT_TAKEN;
      vld_pipe <= {vld_pipe[STAGES-1:1], V_DE && !DE_EX_BUBBLE, v_de_nxt};
      if (accept) epc_q <= V_DE ? DE_PC : FETCH_PC;
    end
  end
endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// Bench for otter_pipe_ctrl: directed scenarios plus a randomized run against
// a cycle-level behavioural model of the pipeline/interrupt rules.
module tb_otter_pipe_ctrl;
  localparam int SYNC = 2;

  logic        CLK = 1'b0, RESET_N = 1'b0, PROG_RESET, INTR, MIE;
  logic [31:0] FETCH_PC, DE_PC, EX_PC, EPC;
  logic [4:0]  DE_RS1_ADDR, DE_RS2_ADDR, EX_RD_ADDR;
  logic        DE_RS1_USED, DE_RS2_USED, EX_MEM_READ, EX_REDIRECT;
  logic        PC_WRITE, IF_ID_WRITE, DE_EX_BUBBLE, INT_TAKEN;
  logic        V_DE, V_EX, V_MEM, V_WB;
  logic [3:0]  ctl, vld;
  int          n_cmp = 0, n_fail = 0;

  assign ctl = {PC_WRITE, IF_ID_WRITE, DE_EX_BUBBLE, INT_TAKEN};
  assign vld = {V_DE, V_EX, V_MEM, V_WB};

  always #5 CLK = ~CLK;

  otter_pipe_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PROG_RESET(PROG_RESET), .INTR(INTR), .MIE(MIE),
    .FETCH_PC(FETCH_PC), .DE_PC(DE_PC),
    .DE_RS1_ADDR(DE_RS1_ADDR), .DE_RS2_ADDR(DE_RS2_ADDR),
    .DE_RS1_USED(DE_RS1_USED), .DE_RS2_USED(DE_RS2_USED),
    .EX_PC(EX_PC), .EX_RD_ADDR(EX_RD_ADDR), .EX_MEM_READ(EX_MEM_READ),
    .EX_REDIRECT(EX_REDIRECT), .PC_WRITE(PC_WRITE), .IF_ID_WRITE(IF_ID_WRITE),
    .DE_EX_BUBBLE(DE_EX_BUBBLE), .INT_TAKEN(INT_TAKEN), .EPC(EPC),
    .V_DE(V_DE), .V_EX(V_EX), .V_MEM(V_MEM), .V_WB(V_WB)
  );

  task automatic defaults();
    PROG_RESET = 1'b0; INTR = 1'b0; MIE = 1'b1;
    FETCH_PC = 32'h104; DE_PC = 32'h100; EX_PC = 32'hfc;
    DE_RS1_ADDR = '0; DE_RS2_ADDR = '0; DE_RS1_USED = 1'b0; DE_RS2_USED = 1'b0;
    EX_RD_ADDR = '0; EX_MEM_READ = 1'b0; EX_REDIRECT = 1'b0;
  endtask

  // Ends on a negedge with reset released and `fill` edges elapsed.
  task automatic do_reset(input int fill);
    @(negedge CLK); RESET_N = 1'b0; defaults();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (fill) @(negedge CLK);
  endtask

  task automatic test_reset();
    defaults();
    repeat (2) @(negedge CLK); #1;
    n_cmp++;
    if ({ctl, vld} !== 8'b1100_0000 || EPC !== 32'h0) begin
      n_fail++; $display("FAIL reset_vals: got %b epc %h want 11000000 epc 0", {ctl, vld}, EPC);
    end
    RESET_N = 1'b1; #1;
    n_cmp++;
    if (vld !== 4'b0000) begin n_fail++; $display("FAIL reset_release: got %b want 0000", vld); end
    @(negedge CLK); #1;
    n_cmp++;
    if (vld !== 4'b1000) begin n_fail++; $display("FAIL first_vde: got %b want 1000", vld); end
  endtask

  task automatic test_load_use();
    do_reset(4);
    EX_MEM_READ = 1'b1; EX_RD_ADDR = 5'd5; DE_RS2_USED = 1'b1; DE_RS2_ADDR = 5'd5;
    DE_RS1_USED = 1'b1; DE_RS1_ADDR = 5'd6; #1;
    n_cmp++;
    if (ctl !== 4'b0010) begin n_fail++; $display("FAIL lu_stall: got %b want 0010", ctl); end
    @(negedge CLK); EX_MEM_READ = 1'b0; EX_RD_ADDR = 5'd7; #1;
    n_cmp++;
    if ({ctl, vld} !== 8'b1100_1011) begin
      n_fail++; $display("FAIL lu_after: got %b want 11001011", {ctl, vld});
    end
    @(negedge CLK);
    EX_MEM_READ = 1'b1; EX_RD_ADDR = 5'd0; DE_RS1_ADDR = 5'd0; DE_RS2_ADDR = 5'd0; #1;
    n_cmp++;
    if ({ctl, vld} !== 8'b1100_1101) begin
      n_fail++; $display("FAIL lu_x0: got %b want 11001101", {ctl, vld});
    end
  endtask

  task automatic test_redirect_stall();
    do_reset(4);
    EX_MEM_READ = 1'b1; EX_RD_ADDR = 5'd9; DE_RS1_USED = 1'b1; DE_RS1_ADDR = 5'd9;
    EX_REDIRECT = 1'b1; #1;
    n_cmp++;
    if ({PC_WRITE, DE_EX_BUBBLE} !== 2'b11) begin
      n_fail++; $display("FAIL redir_ctl: got %b want 11", {PC_WRITE, DE_EX_BUBBLE});
    end
    @(negedge CLK); defaults(); #1;
    n_cmp++;
    if (vld !== 4'b0011) begin n_fail++; $display("FAIL redir_v1: got %b want 0011", vld); end
    @(negedge CLK); #1;
    n_cmp++;
    if (vld !== 4'b1001) begin n_fail++; $display("FAIL redir_v2: got %b want 1001", vld); end
  endtask

  task automatic test_interrupt();
    do_reset(4);
    INTR = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (k == 3) INTR = 1'b0;
      #1;
      n_cmp++;
      if (INT_TAKEN !== (k == 7)) begin
        n_fail++; $display("FAIL int_pulse c%0d: got %b want %b", k, INT_TAKEN, (k == 7));
      end
      if (k == 7) begin
        n_cmp++;
        if (EPC !== 32'h100 || vld !== 4'b0000) begin
          n_fail++; $display("FAIL int_take: got epc %h vld %b want 100 0000", EPC, vld);
        end
      end
      if (k == 9) begin
        n_cmp++;
        if (V_DE !== 1'b1) begin n_fail++; $display("FAIL int_mtvec_de: got %b want 1", V_DE); end
      end
    end
  endtask

  task automatic test_blocked();
    int pulses = 0;
    do_reset(4);
    INTR = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      if (k == 3) EX_REDIRECT = 1'b1;
      if (k == 4) begin EX_REDIRECT = 1'b0; FETCH_PC = 32'h200; INTR = 1'b0; end
      #1;
      if (k == 3) begin
        n_cmp++;
        if (ctl !== 4'b1110) begin n_fail++; $display("FAIL blk_defer: got %b want 1110", ctl); end
      end
      if (k == 4) begin
        n_cmp++;
        if (ctl !== 4'b0110) begin n_fail++; $display("FAIL blk_accept: got %b want 0110", ctl); end
      end
      if (INT_TAKEN) begin
        pulses++;
        n_cmp++;
        if (EPC !== 32'h200) begin n_fail++; $display("FAIL blk_epc: got %h want 200", EPC); end
      end
    end
    n_cmp++;
    if (pulses != 1) begin n_fail++; $display("FAIL blk_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_reset_mid_drain();
    int pulses = 0;
    do_reset(4);
    INTR = 1'b1;
    repeat (5) @(negedge CLK);
    #1;
    n_cmp++;
    if (ctl !== 4'b0110) begin n_fail++; $display("FAIL rst_drain_pre: got %b want 0110", ctl); end
    INTR = 1'b0; RESET_N = 1'b0; #1;
    n_cmp++;
    if ({ctl, vld} !== 8'b1100_0000 || EPC !== 32'h0) begin
      n_fail++; $display("FAIL rst_drain_async: got %b epc %h want 11000000 epc 0", {ctl, vld}, EPC);
    end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1; #1;
    n_cmp++;
    if (vld !== 4'b0000) begin n_fail++; $display("FAIL rst_drain_rel: got %b want 0000", vld); end
    @(negedge CLK); #1;
    n_cmp++;
    if (vld !== 4'b1000) begin n_fail++; $display("FAIL rst_drain_vde: got %b want 1000", vld); end
    repeat (10) begin @(negedge CLK); #1; if (INT_TAKEN) pulses++; end
    n_cmp++;
    if (pulses != 0) begin n_fail++; $display("FAIL rst_drain_noint: got %0d want 0", pulses); end
  endtask

  task automatic test_prog_reset();
    int pulses = 0;
    do_reset(4);
    INTR = 1'b1;
    repeat (5) @(negedge CLK);
    INTR = 1'b0; PROG_RESET = 1'b1; #1;
    n_cmp++;
    if (ctl !== 4'b0110) begin n_fail++; $display("FAIL prst_pre: got %b want 0110", ctl); end
    @(negedge CLK); PROG_RESET = 1'b0; #1;
    n_cmp++;
    if ({ctl, vld} !== 8'b1100_0000 || EPC !== 32'h0) begin
      n_fail++; $display("FAIL prst_clear: got %b epc %h want 11000000 epc 0", {ctl, vld}, EPC);
    end
    repeat (8) begin @(negedge CLK); #1; if (INT_TAKEN) pulses++; end
    MIE = 1'b0; INTR = 1'b1;
    repeat (12) begin @(negedge CLK); #1; if (INT_TAKEN) pulses++; end
    INTR = 1'b0;
    repeat (4) begin @(negedge CLK); #1; if (INT_TAKEN) pulses++; end
    n_cmp++;
    if (pulses != 0) begin n_fail++; $display("FAIL prst_mie0: got %0d pulses want 0", pulses); end
  endtask

  // Model: valid bits as an array, INTR synchronizer as a delay queue,
  // interrupt entry as "draining" / "taking" flags.
  task automatic test_random(input int cycles);
    bit          mv[4];
    bit          mq[$];
    bit          mpend, mdrain, mtake, st, rdr, acc, pcw, bub, isync, nv0, nd, nt;
    logic [31:0] mepc;
    logic [7:0]  exp_v;
    do_reset(0);
    mv = '{default: 1'b0}; mq = {};
    for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);
    mpend = 1'b0; mdrain = 1'b0; mtake = 1'b0; mepc = '0;
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 7) == 0) INTR = ~INTR;
      MIE         = ($urandom_range(0, 9) != 0);
      PROG_RESET  = ($urandom_range(0, 149) == 0);
      FETCH_PC    = $urandom; DE_PC = $urandom; EX_PC = $urandom;
      DE_RS1_ADDR = 5'($urandom_range(0, 3)); DE_RS2_ADDR = 5'($urandom_range(0, 3));
      EX_RD_ADDR  = 5'($urandom_range(0, 3));
      DE_RS1_USED = ($urandom_range(0, 3) != 0); DE_RS2_USED = ($urandom_range(0, 3) != 0);
      EX_MEM_READ = $urandom_range(0, 1) == 1;
      EX_REDIRECT = ($urandom_range(0, 7) == 0);
      #1;
      st  = mv[1] && EX_MEM_READ && (EX_RD_ADDR != 0) && mv[0] &&
            ((DE_RS1_USED && DE_RS1_ADDR == EX_RD_ADDR) || (DE_RS2_USED && DE_RS2_ADDR == EX_RD_ADDR));
      rdr = !mdrain && !mtake && mv[1] && EX_REDIRECT;
      acc = !mdrain && !mtake && mpend && !st && !rdr;
      pcw = mtake || (!mdrain && !acc && (!st || rdr));
      bub = mdrain || st || rdr || acc;
      exp_v = {pcw, !st, bub, mtake, mv[0], mv[1], mv[2], mv[3]};
      n_cmp++;
      if ({ctl, vld} !== exp_v) begin
        n_fail++; $display("FAIL rand_ctl c%0d: got %b want %b", c, {ctl, vld}, exp_v);
      end
      n_cmp++;
      if (EPC !== mepc) begin n_fail++; $display("FAIL rand_epc c%0d: got %h want %h", c, EPC, mepc); end
      if (PROG_RESET) begin
        mv = '{default: 1'b0}; mpend = 1'b0; mdrain = 1'b0; mtake = 1'b0; mepc = '0;
        for (int i = 0; i < SYNC; i++) mq[i] = 1'b0;
      end else begin
        isync = mq[0];
        mq.push_back(INTR); void'(mq.pop_front());
        mpend = (mpend || (isync && MIE)) && !mtake;
        if (acc) mepc = mv[0] ? DE_PC : FETCH_PC;
        nd  = acc || (mdrain && (mv[2] || mv[3]));
        nt  = mdrain && !mv[2] && !mv[3];
        nv0 = (rdr || mdrain || mtake || acc) ? 1'b0 : (st ? mv[0] : 1'b1);
        mv[3] = mv[2]; mv[2] = mv[1]; mv[1] = mv[0] && !bub; mv[0] = nv0;
        mdrain = nd; mtake = nt;
      end
      @(negedge CLK);
    end
    defaults();
  endtask

  initial begin
    defaults();
    test_reset();
    test_load_use();
    test_redirect_stall();
    test_interrupt();
    test_blocked();
    test_reset_mid_drain();
    test_prog_reset();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
